serial_and_deserializer: RTL and testbench

//   Bit-serial consumer of a 1-bit AND stage: each accepted beat forms a&b

---
 rtl/serial_and_deserializer.sv | 120 ++++++++++++
 tb/tb_serial_and_deserializer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/serial_and_deserializer.sv
// Purpose : bit-serial a&b collector; packs accepted beats LSB first into a
//           WIDTH-bit word and presents it with a reduction-AND flag.
// Latency : down_valid rises the cycle after the last beat of a word is taken;
//           sustained rate is one word per WIDTH cycles with no bubbles.
// Backpressure: while a word waits on down_ready, the next word is collected
//           up to its last bit and up_ready then drops until the word drains.
//
// Ports
//   clk, rst                 clock and synchronous active-high reset
//   up_valid / up_ready      serial beat handshake (a, b sampled on accept)
//   a, b                     serial operand bits
//   down_valid / down_ready  word handshake
//   down_data                packed a&b bits, first accepted beat in bit 0
//   down_all_ones            &down_data, registered alongside down_data

// Single AND built from a 2:1 mux: b selects between a and constant 0.
module and_gate_using_mux (
  input  logic i_a,
  input  logic i_b,
  output logic o_y
);

  assign o_y = i_b ? i_a : 1'b0;

endmodule

module serial_and_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic             a,
  input  logic             b,
  output logic             down_valid,
  input  logic             down_ready,
  output logic [WIDTH-1:0] down_data,
  output logic             down_all_ones
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  // Collection state: bit position of the next beat and the lower WIDTH-1
  // bits of the word being assembled. The top bit never needs storage since
  // it goes straight into the output register together with the shreg.
  logic [CW-1:0]    r_count;
  logic [WIDTH-2:0] r_shreg;

  // Output register.
  logic [WIDTH-1:0] r_down_data;
  logic             r_down_all_ones;
  logic             r_down_valid;

  logic             w_bit;
  logic             w_last;
  logic             w_accept;
  logic             w_load;
  logic             w_drain;
  logic [WIDTH-1:0] w_word;

  and_gate_using_mux u_and (
    .i_a (a),
    .i_b (b),
    .o_y (w_bit)
  );

  assign w_last   = (r_count == LAST_IDX);

  // Only the final beat of a word can be blocked: it needs the output
  // register, which is free unless a word is sitting there undrained.
  // Earlier beats land in the shreg and are always accepted.
  assign up_ready = !(w_last && r_down_valid && !down_ready);

  assign w_accept = up_valid && up_ready;
  assign w_load   = w_accept && w_last;
  assign w_drain  = r_down_valid && down_ready;
  assign w_word   = {w_bit, r_shreg};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count         <= '0;
      r_shreg         <= '0;
      r_down_data     <= '0;
      r_down_all_ones <= 1'b0;
      r_down_valid    <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_last) begin
          r_count <= '0;
        end else begin
          r_count <= r_count + 1'b1;
          // Positions are rewritten in order, so bits left from the
          // previous word are always replaced before the next load.
          for (int i = 0; i < WIDTH - 1; i++) begin
            if (r_count == CW'(i)) begin
              r_shreg[i] <= w_bit;
            end
          end
        end
      end

      // A load may coincide with a drain of the previous word; the new word
      // wins and down_valid stays high.
      if (w_load) begin
        r_down_data     <= w_word;
        r_down_all_ones <= &w_word;
        r_down_valid    <= 1'b1;
      end else if (w_drain) begin
        r_down_valid    <= 1'b0;
      end
    end
  end

  assign down_data     = r_down_data;
  assign down_all_ones = r_down_all_ones;
  assign down_valid    = r_down_valid;

endmodule

// File: tb/tb_serial_and_deserializer.sv
// Randomized and directed bench for serial_and_deserializer. A behavioural
// model (bit counter, integer word accumulator, one-deep output slot)
// predicts every output each cycle.
module tb_serial_and_deserializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         up_valid;
  logic         up_ready;
  logic         a;
  logic         b;
  logic         down_valid;
  logic         down_ready;
  logic [W-1:0] down_data;
  logic         down_all_ones;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  int           m_nbits;
  logic [W-1:0] m_partial;
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_all;

  serial_and_deserializer #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .up_valid      (up_valid),
    .up_ready      (up_ready),
    .a             (a),
    .b             (b),
    .down_valid    (down_valid),
    .down_ready    (down_ready),
    .down_data     (down_data),
    .down_all_ones (down_all_ones)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_nbits   = 0;
    m_partial = '0;
    m_data    = '0;
    m_valid   = 1'b0;
    m_all     = 1'b0;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    up_valid   = 1'b0;
    a          = 1'b0;
    b          = 1'b0;
    down_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One clock: drive inputs, compare all outputs with the model, then
  // advance the model by the handshakes that happen at the coming edge.
  task automatic cycle(input logic v, input logic ia, input logic ib,
                       input logic dr, output logic acc);
    logic         exp_rdy;
    logic         bit_ab;
    logic         load;
    up_valid   = v;
    a          = ia;
    b          = ib;
    down_ready = dr;
    #1;
    exp_rdy = !((m_nbits == W - 1) && m_valid && !dr);
    check("up_ready",      {31'd0, up_ready},      {31'd0, exp_rdy});
    check("down_valid",    {31'd0, down_valid},    {31'd0, m_valid});
    check("down_data",     {24'd0, down_data},     {24'd0, m_data});
    check("down_all_ones", {31'd0, down_all_ones}, {31'd0, m_all});

    acc    = v && exp_rdy;
    bit_ab = ia & ib;
    load   = acc && (m_nbits == W - 1);
    if (load) begin
      m_data    = m_partial + ({{(W-1){1'b0}}, bit_ab} << (W - 1));
      m_all     = (m_data == {W{1'b1}});
      m_valid   = 1'b1;
      m_nbits   = 0;
      m_partial = '0;
    end else begin
      if (acc) begin
        m_partial = m_partial + ({{(W-1){1'b0}}, bit_ab} << m_nbits);
        m_nbits++;
      end
      if (m_valid && dr) m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // Streams one word; gap_pct is the chance of an idle cycle per attempt.
  task automatic send_word(input logic [W-1:0] wa, input logic [W-1:0] wb,
                           input logic dr, input int gap_pct);
    logic acc;
    logic got;
    for (int i = 0; i < W; i++) begin
      got = 1'b0;
      for (int t = 0; t < 64 && !got; t++) begin
        cycle(($urandom_range(99) >= gap_pct), wa[i], wb[i], dr, acc);
        got = acc;
      end
      check("beat_taken", {31'd0, got}, 32'd1);
    end
  endtask

  task automatic idle(input int n, input logic dr);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, $urandom_range(1), $urandom_range(1), dr, acc);
  endtask

  initial begin
    logic          acc;
    logic [W-1:0]  w2;
    int            taken;

    // 1. Reset state.
    do_reset();
    check("rst_down_valid", {31'd0, down_valid},    32'd0);
    check("rst_down_data",  {24'd0, down_data},     32'd0);
    check("rst_all_ones",   {31'd0, down_all_ones}, 32'd0);
    check("rst_up_ready",   {31'd0, up_ready},      32'd1);

    // 2. Single word, valid for exactly one cycle with down_ready high.
    send_word(8'hF0, 8'hFF, 1'b1, 0);
    check("t2_valid", {31'd0, down_valid}, 32'd1);
    check("t2_data",  {24'd0, down_data},  32'hF0);
    idle(1, 1'b1);
    check("t2_drop",  {31'd0, down_valid}, 32'd0);
    idle(1, 1'b1);

    // 3. All-ones word then a back-to-back word with a cleared top bit.
    send_word(8'hFF, 8'hFF, 1'b1, 0);
    check("t3_all1", {31'd0, down_all_ones}, 32'd1);
    send_word(8'hFF, 8'h7F, 1'b1, 0);
    check("t3_data2", {24'd0, down_data}, 32'h7F);
    idle(2, 1'b1);

    // 4. Backpressure: word 2 stalls on its last bit until word 1 drains.
    send_word(8'hA5, 8'hFF, 1'b1, 0);
    w2    = 8'h3C;
    taken = 0;
    for (int i = 0; i < W - 1; i++) begin
      cycle(1'b1, w2[i], 1'b1, 1'b0, acc);
      taken += int'(acc);
    end
    check("t4_seven_taken", taken, 32'd7);
    cycle(1'b1, w2[W-1], 1'b1, 1'b0, acc);
    check("t4_8th_blocked", {31'd0, acc}, 32'd0);
    check("t4_word1_held",  {24'd0, down_data}, 32'hA5);
    cycle(1'b1, w2[W-1], 1'b1, 1'b1, acc);
    check("t4_8th_taken",   {31'd0, acc}, 32'd1);
    check("t4_word2",       {24'd0, down_data}, 32'h3C);
    check("t4_still_valid", {31'd0, down_valid}, 32'd1);
    idle(2, 1'b1);

    // 5. Gappy upstream.
    send_word(8'h96, 8'hFF, 1'b1, 50);
    check("t5_data", {24'd0, down_data}, 32'h96);
    idle(2, 1'b1);

    // 6. Reset in the middle of a word.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1, 1'b1, acc);
    do_reset();
    send_word(8'h0F, 8'hFF, 1'b1, 0);
    check("t6_data", {24'd0, down_data}, 32'h0F);
    idle(2, 1'b1);

    // Fully random traffic on both sides.
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(99) < 70, $urandom_range(1), $urandom_range(1),
            $urandom_range(99) < 60, acc);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
